// File: rtl/spi_slave_shifter_pkg.sv
// Shared definitions for the SPI slave shifter: state encodings and parameter defaults.
package spi_slave_shifter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam int DW_DEFAULT      = 8;
  localparam int TX_IDLE_DEFAULT = 0;

endpackage

// File: rtl/spi_tx_buf.sv
// Single-entry TX holding register; a pull reads the old content before a same-cycle write lands.
module spi_tx_buf
  import spi_slave_shifter_pkg::*;
#(
  parameter int              DW        = DW_DEFAULT,
  parameter logic [DW-1:0]   IDLE_WORD = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] wr_data,
  input  logic          pull,
  output logic [DW-1:0] pull_data,
  output logic          full
);

  logic [DW-1:0] buf_q;

  assign pull_data = full ? buf_q : IDLE_WORD;

  // A write always wins the flag, so a coincident pull leaves the new word pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      full  <= 1'b0;
    end else if (wr) begin
      buf_q <= wr_data;
      full  <= 1'b1;
    end else if (pull) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave shifter driven by clk-domain SCK edge pulses.
// Optional `SPI_SLAVE_RX_OVERRUN_EN adds a sticky rx_overrun output.
module spi_slave_shifter
  import spi_slave_shifter_pkg::*;
#(
  parameter int            DW        = DW_DEFAULT,
  parameter bit            MSB_FIRST = 1'b1,
  parameter logic [DW-1:0] TX_IDLE   = DW'(TX_IDLE_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sck_pe,
  input  logic          sck_ne,
  input  logic          cs_n,
  input  logic          mosi,
  output logic          miso,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_rd,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_wr,
  output logic          tx_full,
`ifdef SPI_SLAVE_RX_OVERRUN_EN
  output logic          rx_overrun,
`endif
  output logic          busy
);

  localparam int            CW   = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [DW-1:0] rx_sr;
  logic [DW-1:0] tx_sr;
  logic          pending_load;
  logic [DW-1:0] rx_next;
  logic [DW-1:0] tx_shift;
  logic [DW-1:0] pull_data;
  logic          pull;
  logic          word_done;

  function automatic logic out_bit(input logic [DW-1:0] w);
    return MSB_FIRST ? w[DW-1] : w[0];
  endfunction

  always_comb begin
    rx_next  = '0;
    tx_shift = '0;
    if (MSB_FIRST) begin
      rx_next  = {rx_sr[DW-2:0], mosi};
      tx_shift = {tx_sr[DW-2:0], 1'b0};
    end else begin
      rx_next  = {mosi, rx_sr[DW-1:1]};
      tx_shift = {1'b0, tx_sr[DW-1:1]};
    end
  end

  // cs_n has priority over the edge pulses; sck_pe wins over an illegal coincident sck_ne.
  assign word_done = (state == ST_ACTIVE) && !cs_n && sck_pe && (bit_cnt == LAST);
  assign pull      = ((state == ST_IDLE) && !cs_n) ||
                     ((state == ST_ACTIVE) && !cs_n && !sck_pe && sck_ne && pending_load);
  assign busy      = (state == ST_ACTIVE);

  spi_tx_buf #(
    .DW        (DW),
    .IDLE_WORD (TX_IDLE)
  ) u_tx_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (tx_wr),
    .wr_data   (tx_data),
    .pull      (pull),
    .pull_data (pull_data),
    .full      (tx_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      pending_load <= 1'b0;
      miso         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!cs_n) begin
            state        <= ST_ACTIVE;
            tx_sr        <= pull_data;
            miso         <= out_bit(pull_data);
            bit_cnt      <= '0;
            pending_load <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (cs_n) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            rx_sr        <= '0;
            pending_load <= 1'b0;
          end else begin
            miso <= out_bit(tx_sr);
            if (sck_pe) begin
              rx_sr <= rx_next;
              if (bit_cnt == LAST) begin
                bit_cnt      <= '0;
                pending_load <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (sck_ne) begin
              if (pending_load) begin
                tx_sr        <= pull_data;
                pending_load <= 1'b0;
              end else begin
                tx_sr <= tx_shift;
              end
            end
          end
        end
      endcase
    end
  end

  // A completing word keeps rx_valid high even when rx_rd arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (word_done) begin
      rx_data  <= rx_next;
      rx_valid <= 1'b1;
    end else if (rx_rd) begin
      rx_valid <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_RX_OVERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun <= 1'b0;
    end else if (word_done && rx_valid && !rx_rd) begin
      rx_overrun <= 1'b1;
    end else if (rx_rd) begin
      rx_overrun <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Self-checking bench for spi_slave_shifter (DW=8, MSB first, TX_IDLE=0).
module tb_spi_slave_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sck_pe;
  logic       sck_ne;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_rd;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full;
  logic       busy;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
  logic       rx_overrun;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  spi_slave_shifter #(
    .DW        (8),
    .MSB_FIRST (1'b1),
    .TX_IDLE   (8'h00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sck_pe     (sck_pe),
    .sck_ne     (sck_ne),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_rd      (rx_rd),
    .tx_data    (tx_data),
    .tx_wr      (tx_wr),
    .tx_full    (tx_full),
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    .rx_overrun (rx_overrun),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       load;
    logic [7:0] tx;
    logic [7:0] mosi_w;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] w);
    @(negedge clk); tx_data = w; tx_wr = 1'b1;
    @(negedge clk); tx_wr = 1'b0;
  endtask

  task automatic read_rx();
    @(negedge clk); rx_rd = 1'b1;
    @(negedge clk); rx_rd = 1'b0;
  endtask

  // Start of a frame: miso is sampled one negedge after the cs_n-fall edge.
  task automatic select();
    @(negedge clk); cs_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic deselect();
    @(negedge clk); cs_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] w, input int nbits, input logic rd_last,
                           output logic [7:0] got, output logic pre_v, output logic post_v);
    got    = '0;
    pre_v  = 1'b0;
    post_v = 1'b0;
    for (int i = 7; i > 7 - nbits; i--) begin
      got[i] = miso;
      if (i == 0) pre_v = rx_valid;
      @(negedge clk); mosi = w[i]; sck_pe = 1'b1; rx_rd = rd_last && (i == 0);
      @(negedge clk); sck_pe = 1'b0; rx_rd = 1'b0;
      if (i == 0) post_v = rx_valid;
      @(negedge clk); sck_ne = 1'b1;
      @(negedge clk); sck_ne = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] got;
    logic       pre_v;
    logic       post_v;

    rst_n = 1'b0; sck_pe = 1'b0; sck_ne = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    rx_rd = 1'b0; tx_data = '0; tx_wr = 1'b0;

    vecs[0] = '{1'b0, 8'h00, 8'hA5, 8'h00, 8'hA5};
    vecs[1] = '{1'b1, 8'h3C, 8'h5A, 8'h3C, 8'h5A};
    vecs[2] = '{1'b1, 8'hC3, 8'h0F, 8'hC3, 8'h0F};
    vecs[3] = '{1'b0, 8'hFF, 8'h96, 8'h00, 8'h96};

    tick(3);
    check_output("reset_outputs", {miso, rx_data, rx_valid, tx_full, busy}, 32'h0);
    rst_n = 1'b1;
    tick(1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); sck_pe = 1'b1; mosi = 1'b1;
      @(negedge clk); sck_pe = 1'b0; sck_ne = 1'b1;
      @(negedge clk); sck_ne = 1'b0;
    end
    tick(1);
    check_output("idle_pulses_ignored", {miso, rx_data, rx_valid, tx_full, busy}, 32'h0);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].load) begin
        write_tx(vecs[v].tx);
        check_output($sformatf("v%0d_tx_full_loaded", v), tx_full, 1);
      end
      select();
      check_output($sformatf("v%0d_busy", v), busy, 1);
      check_output($sformatf("v%0d_tx_full_cleared", v), tx_full, 0);
      send_bits(vecs[v].mosi_w, 8, 1'b0, got, pre_v, post_v);
      check_output($sformatf("v%0d_miso", v), got, vecs[v].exp_miso);
      check_output($sformatf("v%0d_rx_valid_pre", v), pre_v, 0);
      check_output($sformatf("v%0d_rx_valid_post", v), post_v, 1);
      check_output($sformatf("v%0d_rx_data", v), rx_data, vecs[v].exp_rx);
      read_rx();
      check_output($sformatf("v%0d_rx_valid_cleared", v), rx_valid, 0);
      deselect();
      check_output($sformatf("v%0d_busy_idle", v), busy, 0);
    end

    // Back-to-back: empty buffer sends TX_IDLE; a word written mid-frame goes out two words later.
    select();
    send_bits(8'h5A, 8, 1'b0, got, pre_v, post_v);
    check_output("b2b_w1_miso", got, 8'h00);
    check_output("b2b_w1_rx", rx_data, 8'h5A);
    read_rx();
    write_tx(8'hE7);
    send_bits(8'hC3, 8, 1'b0, got, pre_v, post_v);
    check_output("b2b_w2_miso", got, 8'h00);
    check_output("b2b_w2_rx", rx_data, 8'hC3);
    check_output("b2b_w2_valid", rx_valid, 1);
    check_output("b2b_tx_pulled", tx_full, 0);
    read_rx();
    send_bits(8'h00, 8, 1'b0, got, pre_v, post_v);
    check_output("b2b_w3_miso", got, 8'hE7);
    read_rx();
    deselect();

    // Pull and write on the same edge: old word goes out first, new word stays pending.
    write_tx(8'h11);
    @(negedge clk); cs_n = 1'b0; tx_data = 8'h22; tx_wr = 1'b1;
    @(negedge clk); tx_wr = 1'b0;
    check_output("pull_wr_full", tx_full, 1);
    send_bits(8'h00, 8, 1'b0, got, pre_v, post_v);
    check_output("pull_wr_first", got, 8'h11);
    read_rx();
    send_bits(8'h00, 8, 1'b0, got, pre_v, post_v);
    check_output("pull_wr_second", got, 8'h22);
    read_rx();
    deselect();

    // Abort after 5 bits, then a full word must still frame correctly.
    select();
    send_bits(8'hFF, 5, 1'b0, got, pre_v, post_v);
    deselect();
    check_output("abort_no_valid", rx_valid, 0);
    check_output("abort_idle", busy, 0);
    select();
    send_bits(8'h81, 8, 1'b0, got, pre_v, post_v);
    check_output("abort_next_rx", rx_data, 8'h81);
    check_output("abort_next_valid", rx_valid, 1);

    // rx_rd coinciding with completion keeps rx_valid for the new word.
    send_bits(8'h3E, 8, 1'b1, got, pre_v, post_v);
    check_output("rd_coincide_valid", post_v, 1);
    check_output("rd_coincide_data", rx_data, 8'h3E);
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    check_output("rd_coincide_no_overrun", rx_overrun, 0);
`endif
    read_rx();
    deselect();

`ifdef SPI_SLAVE_RX_OVERRUN_EN
    select();
    send_bits(8'h11, 8, 1'b0, got, pre_v, post_v);
    check_output("ovr_first_clear", rx_overrun, 0);
    send_bits(8'h22, 8, 1'b0, got, pre_v, post_v);
    check_output("ovr_data", rx_data, 8'h22);
    check_output("ovr_set", rx_overrun, 1);
    read_rx();
    check_output("ovr_cleared", rx_overrun, 0);
    check_output("ovr_valid_cleared", rx_valid, 0);
    deselect();
`endif

    // Reset mid-transfer clears state immediately.
    write_tx(8'hFF);
    select();
    send_bits(8'h00, 3, 1'b0, got, pre_v, post_v);
    check_output("pre_reset_miso", miso, 1);
    rst_n = 1'b0;
    #1;
    check_output("async_reset", {miso, rx_valid, tx_full, busy}, 32'h0);
    cs_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check_output("post_reset_idle", {miso, rx_data, rx_valid, tx_full, busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
